// File: rtl/cc_capture_pkg.sv
// Shared types and helpers for the cc_capture_ctrl camera capture gate.
// Holds the one-hot state codes, sync-source selectors and the saturating increment.
package cc_capture_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] ST_IDLE = 5'b00001;
    localparam logic [STATE_W-1:0] ST_ARM  = 5'b00010;
    localparam logic [STATE_W-1:0] ST_SKIP = 5'b00100;
    localparam logic [STATE_W-1:0] ST_PASS = 5'b01000;
    localparam logic [STATE_W-1:0] ST_DONE = 5'b10000;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = ST_IDLE,
        S_ARM  = ST_ARM,
        S_SKIP = ST_SKIP,
        S_PASS = ST_PASS,
        S_DONE = ST_DONE
    } cc_state_e;

    localparam logic SYNC_VSYNC = 1'b0;
    localparam logic SYNC_HSYNC = 1'b1;

    // Callers pass the counter zero-extended to 64 bits and truncate the result back.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] lim;
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= lim) ? lim : val + 64'd1;
    endfunction

endpackage

// File: rtl/cc_capture_ctrl_if.sv
// Camera-side and control/status bundle for cc_capture_ctrl.
// slave is the capture gate itself; master is whatever drives the camera pins and control.
interface cc_capture_ctrl_if #(
    parameter int DATA_W   = 16,
    parameter int FRAMES_W = 8,
    parameter int COUNT_W  = 32
);
    logic [DATA_W-1:0]   cmos_data_i;
    logic                cmos_vsync_i;
    logic                cmos_hsync_i;
    logic                cmos_valid_i;
    logic                sync_sel_i;
    logic                arm_i;
    logic                abort_i;
    logic [FRAMES_W-1:0] skip_i;
    logic [FRAMES_W-1:0] frames_i;

    logic [DATA_W-1:0]   cmos_data_o;
    logic                cmos_en_o;
    logic                cmos_reset_o;
    logic                busy_o;
    logic                done_o;
    logic [COUNT_W-1:0]  data_count_o;
    logic [FRAMES_W-1:0] frame_count_o;
    logic [15:0]         lines_o;

    modport master (
        output cmos_data_i, cmos_vsync_i, cmos_hsync_i, cmos_valid_i,
        output sync_sel_i, arm_i, abort_i, skip_i, frames_i,
        input  cmos_data_o, cmos_en_o, cmos_reset_o, busy_o, done_o,
        input  data_count_o, frame_count_o, lines_o
    );

    modport slave (
        input  cmos_data_i, cmos_vsync_i, cmos_hsync_i, cmos_valid_i,
        input  sync_sel_i, arm_i, abort_i, skip_i, frames_i,
        output cmos_data_o, cmos_en_o, cmos_reset_o, busy_o, done_o,
        output data_count_o, frame_count_o, lines_o
    );

endinterface

// File: rtl/cc_capture_ctrl_edge_detect.sv
// Two-flop sync sampler producing a one-cycle pulse on a falling edge.
// Samples reset low so a sync that is already low at reset release never looks like an edge.
module cc_edge_detect (
    input  logic clk_i,
    input  logic rst_n,
    input  logic sync_i,
    output logic fall_o
);

    logic [1:0] smp_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= 2'b00;
        end else begin
            smp_q <= {smp_q[0], sync_i};
        end
    end

    assign fall_o = smp_q[1] & ~smp_q[0];

endmodule

// File: rtl/cc_capture_ctrl.sv
// Capture gate between the parallel camera pins and the capture FIFO: arm, skip, burst, abort.
// Optional per-frame line counter is built when CC_CAPTURE_LINES_EN is defined.
//
// state | meaning
// IDLE  | waiting for arm_i
// ARM   | armed, waiting for the first boundary
// SKIP  | discarding skip_i boundaries
// PASS  | forwarding valid pixels, counting passed boundaries
// DONE  | one-cycle done_o, then back to IDLE
module cc_capture_ctrl
    import cc_capture_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAMES_W = 8,
    parameter int COUNT_W  = 32
) (
    input  logic             cmos_clk_i,
    input  logic             rst_n,
    cc_capture_ctrl_if.slave cap
);

    cc_state_e           state_q;
    logic [FRAMES_W-1:0] skip_q;
    logic [FRAMES_W-1:0] frame_q;
    logic [FRAMES_W-1:0] frame_d;
    logic [FRAMES_W-1:0] frames_eff;
    logic [COUNT_W-1:0]  data_cnt_q;
    logic [COUNT_W-1:0]  data_cnt_d;
    logic [DATA_W-1:0]   data_q;
    logic                en_q;
    logic                sync_mux;
    logic                sel_fall;
    logic                pass_beat;

    // A change of sync_sel_i can fake one edge here; it is only changed in IDLE.
    assign sync_mux = (cap.sync_sel_i == SYNC_HSYNC) ? cap.cmos_hsync_i : cap.cmos_vsync_i;

    cc_edge_detect u_sel_edge (
        .clk_i  (cmos_clk_i),
        .rst_n  (rst_n),
        .sync_i (sync_mux),
        .fall_o (sel_fall)
    );

    assign frames_eff = (cap.frames_i == '0) ? FRAMES_W'(1) : cap.frames_i;
    assign frame_d    = FRAMES_W'(sat_inc(64'(frame_q), FRAMES_W));
    assign data_cnt_d = COUNT_W'(sat_inc(64'(data_cnt_q), COUNT_W));
    assign pass_beat  = (state_q == S_PASS) & cap.cmos_valid_i & ~cap.abort_i;

    always_ff @(posedge cmos_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            skip_q     <= '0;
            frame_q    <= '0;
            data_cnt_q <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            data_q <= cap.cmos_data_i;
            en_q   <= pass_beat;
            if (pass_beat) begin
                data_cnt_q <= data_cnt_d;
            end

            if (cap.abort_i) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cap.arm_i) begin
                            skip_q     <= cap.skip_i;
                            frame_q    <= '0;
                            data_cnt_q <= '0;
                            state_q    <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (sel_fall) begin
                            state_q <= (skip_q != '0) ? S_SKIP : S_PASS;
                        end
                    end
                    S_SKIP: begin
                        if (sel_fall) begin
                            skip_q <= skip_q - FRAMES_W'(1);
                            if (skip_q == FRAMES_W'(1)) begin
                                state_q <= S_PASS;
                            end
                        end
                    end
                    S_PASS: begin
                        if (sel_fall) begin
                            frame_q <= frame_d;
                            if (frame_d >= frames_eff) begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CC_CAPTURE_LINES_EN
    logic        hs_fall;
    logic        vs_fall;
    logic        arm_start;
    logic [15:0] line_cnt_q;
    logic [15:0] lines_q;

    // Dedicated samplers so line counting does not depend on which sync drives the FSM.
    cc_edge_detect u_hs_edge (
        .clk_i  (cmos_clk_i),
        .rst_n  (rst_n),
        .sync_i (cap.cmos_hsync_i),
        .fall_o (hs_fall)
    );

    cc_edge_detect u_vs_edge (
        .clk_i  (cmos_clk_i),
        .rst_n  (rst_n),
        .sync_i (cap.cmos_vsync_i),
        .fall_o (vs_fall)
    );

    assign arm_start = (state_q == S_IDLE) & cap.arm_i & ~cap.abort_i;

    always_ff @(posedge cmos_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
            lines_q    <= '0;
        end else if (arm_start) begin
            line_cnt_q <= '0;
            lines_q    <= '0;
        end else if ((state_q == S_PASS) && !cap.abort_i) begin
            if (vs_fall) begin
                lines_q    <= line_cnt_q;
                line_cnt_q <= '0;
            end else if (hs_fall) begin
                line_cnt_q <= 16'(sat_inc(64'(line_cnt_q), 16));
            end
        end
    end

    assign cap.lines_o = lines_q;
`else
    assign cap.lines_o = '0;
`endif

    assign cap.cmos_data_o   = data_q;
    assign cap.cmos_en_o     = en_q;
    assign cap.cmos_reset_o  = ~rst_n;
    assign cap.busy_o        = (state_q == S_ARM) | (state_q == S_SKIP) | (state_q == S_PASS);
    assign cap.done_o        = (state_q == S_DONE);
    assign cap.data_count_o  = data_cnt_q;
    assign cap.frame_count_o = frame_q;

endmodule

// File: tb/tb_cc_capture_ctrl.sv
// Self-checking bench for cc_capture_ctrl: frame-level reference model plus a pixel scoreboard.
// A second instance with a 4-bit word counter shares the stimulus to exercise saturation.
module tb_cc_capture_ctrl;

    localparam int DATA_W   = 16;
    localparam int FRAMES_W = 8;
    localparam int COUNT_W  = 32;
    localparam int SAT_W    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_capture_ctrl_if #(.DATA_W(DATA_W), .FRAMES_W(FRAMES_W), .COUNT_W(COUNT_W)) cap ();
    cc_capture_ctrl_if #(.DATA_W(DATA_W), .FRAMES_W(FRAMES_W), .COUNT_W(SAT_W))   sat ();

    cc_capture_ctrl #(.DATA_W(DATA_W), .FRAMES_W(FRAMES_W), .COUNT_W(COUNT_W)) dut (
        .cmos_clk_i (clk),
        .rst_n      (rst_n),
        .cap        (cap)
    );

    cc_capture_ctrl #(.DATA_W(DATA_W), .FRAMES_W(FRAMES_W), .COUNT_W(SAT_W)) dut_sat (
        .cmos_clk_i (clk),
        .rst_n      (rst_n),
        .cap        (sat)
    );

    assign sat.cmos_data_i  = cap.cmos_data_i;
    assign sat.cmos_vsync_i = cap.cmos_vsync_i;
    assign sat.cmos_hsync_i = cap.cmos_hsync_i;
    assign sat.cmos_valid_i = cap.cmos_valid_i;
    assign sat.sync_sel_i   = cap.sync_sel_i;
    assign sat.arm_i        = cap.arm_i;
    assign sat.abort_i      = cap.abort_i;
    assign sat.skip_i       = cap.skip_i;
    assign sat.frames_i     = cap.frames_i;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    int exp_words = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every cmos_en_o beat must match the next expected pixel.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cap.done_o === 1'b1) done_seen++;
            if (cap.cmos_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {48'd0, cap.cmos_data_o}, 64'hDEAD);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat_data", {48'd0, cap.cmos_data_o}, {48'd0, mon_exp});
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap.cmos_valid_i = 1'b0;
            cap.cmos_vsync_i = 1'b0;
            cap.cmos_hsync_i = 1'b0;
            cap.arm_i        = 1'b0;
            cap.abort_i      = 1'b0;
        end
    endtask

    task automatic drive_sync(input bit sel, input bit v);
        if (sel) begin
            cap.cmos_hsync_i = v;
            cap.cmos_vsync_i = 1'b0;
        end else begin
            cap.cmos_vsync_i = v;
            cap.cmos_hsync_i = 1'b0;
        end
    endtask

    // w valid words (hsync pulse on every 4th when hs_en), then a 2-cycle gap.
    task automatic send_words(input int w, input bit hs_en, input bit push, output int nl);
        nl = 0;
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            cap.cmos_valid_i = 1'b1;
            cap.cmos_data_i  = DATA_W'($urandom);
            cap.cmos_hsync_i = hs_en && (k % 4 == 1);
            if (hs_en && (k % 4 == 1)) nl++;
            if (push) begin
                exp_q.push_back(cap.cmos_data_i);
                exp_words++;
            end
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            cap.cmos_valid_i = 1'b0;
            cap.cmos_hsync_i = 1'b0;
        end
    endtask

    // Boundary pulse, then an optional pixel in the boundary cycle (belongs to the
    // segment being closed), then the body of the new segment.
    task automatic send_frame(input bit sel, input bit do_arm, input bit tail_push,
                              input int w, input bit push, output int nl);
        bit tail;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cap.arm_i        = do_arm && (c == 0);
            cap.cmos_valid_i = 1'b0;
            drive_sync(sel, 1'b1);
        end
        @(negedge clk);
        cap.arm_i = 1'b0;
        drive_sync(sel, 1'b0);
        @(negedge clk);
        tail = 1'($urandom_range(1, 0));
        cap.cmos_valid_i = tail;
        cap.cmos_data_i  = DATA_W'($urandom);
        if (tail && tail_push) begin
            exp_q.push_back(cap.cmos_data_i);
            exp_words++;
        end
        send_words(w, !sel, push, nl);
    endtask

    // Boundary b counted from arm: segments b in [skip+1, skip+F] pass; boundary skip+F+1 closes.
    task automatic run_capture(input string tag, input bit sel, input int skip, input int frm,
                               input int arm_at, input int extra, input int wmin, input int wmax);
        int feff, nfr, rel, w, nl, exp_lines;
        bit seg_prev, seg;
        feff = (frm == 0) ? 1 : frm;
        nfr  = arm_at + skip + feff + extra;
        exp_words = 0;
        exp_lines = 0;
        done_seen = 0;
        @(negedge clk);
        cap.sync_sel_i = sel;
        cap.skip_i     = FRAMES_W'(skip);
        cap.frames_i   = FRAMES_W'(frm);
        idle(4);
        for (int f = 1; f <= nfr; f++) begin
            rel      = f - arm_at + 1;
            seg_prev = (rel - 1 >= skip + 1) && (rel - 1 <= skip + feff);
            seg      = (rel >= skip + 1) && (rel <= skip + feff);
            w        = int'($urandom_range(wmax, wmin));
            send_frame(sel, f == arm_at, seg_prev, w, seg, nl);
            if (seg && rel == skip + feff) exp_lines = nl;
        end
        idle(6);
        check({tag, "_data_count"}, 64'(cap.data_count_o), 64'(exp_words));
        check({tag, "_sat_count"}, 64'(sat.data_count_o), 64'((exp_words > 15) ? 15 : exp_words));
        check({tag, "_frame_count"}, 64'(cap.frame_count_o), 64'(feff));
        check({tag, "_done_pulses"}, 64'(done_seen), 64'd1);
        check({tag, "_busy"}, 64'(cap.busy_o), 64'd0);
        check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
`ifdef CC_CAPTURE_LINES_EN
        check({tag, "_lines"}, 64'(cap.lines_o), sel ? 64'd0 : 64'(exp_lines));
`else
        check({tag, "_lines"}, 64'(cap.lines_o), 64'd0);
`endif
    endtask

    initial begin
        int nl;
        cap.cmos_data_i  = '0;
        cap.cmos_vsync_i = 1'b0;
        cap.cmos_hsync_i = 1'b0;
        cap.cmos_valid_i = 1'b0;
        cap.sync_sel_i   = 1'b0;
        cap.arm_i        = 1'b0;
        cap.abort_i      = 1'b0;
        cap.skip_i       = '0;
        cap.frames_i     = 8'd1;

        #12;
        check("rst_reset_o", 64'(cap.cmos_reset_o), 64'd1);
        check("rst_en", 64'(cap.cmos_en_o), 64'd0);
        check("rst_data", 64'(cap.cmos_data_o), 64'd0);
        check("rst_busy", 64'(cap.busy_o), 64'd0);
        check("rst_done", 64'(cap.done_o), 64'd0);
        check("rst_count", 64'(cap.data_count_o), 64'd0);
        check("rst_frames", 64'(cap.frame_count_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("rel_reset_o", 64'(cap.cmos_reset_o), 64'd0);

        run_capture("basic", 1'b0, 0, 1, 2, 0, 100, 100);
        run_capture("skip_burst", 1'b0, 2, 3, 1, 0, 64, 64);
        run_capture("frames0", 1'b0, 0, 0, 1, 1, 20, 30);
        run_capture("lines10", 1'b0, 0, 1, 1, 0, 40, 40);
        run_capture("line_mode", 1'b1, 0, 2, 1, 0, 3, 8);
        for (int r = 0; r < 5; r++) begin
            run_capture("rand", 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                        int'($urandom_range(3, 0)), int'($urandom_range(2, 1)),
                        int'($urandom_range(1, 0)), 1, 30);
        end

        // Abort mid-PASS after 40 words: counters hold, no done pulse.
        exp_words = 0;
        done_seen = 0;
        @(negedge clk);
        cap.sync_sel_i = 1'b0;
        cap.skip_i     = '0;
        cap.frames_i   = 8'd2;
        idle(3);
        send_frame(1'b0, 1'b1, 1'b0, 0, 1'b0, nl);
        send_words(40, 1'b0, 1'b1, nl);
        @(negedge clk);
        cap.abort_i      = 1'b1;
        cap.cmos_valid_i = 1'b1;
        cap.cmos_data_i  = DATA_W'($urandom);
        @(negedge clk);
        cap.abort_i      = 1'b0;
        cap.cmos_valid_i = 1'b0;
        check("abort_busy", 64'(cap.busy_o), 64'd0);
        check("abort_en", 64'(cap.cmos_en_o), 64'd0);
        check("abort_count", 64'(cap.data_count_o), 64'd40);
        check("abort_frames", 64'(cap.frame_count_o), 64'd0);
        send_frame(1'b0, 1'b0, 1'b0, 10, 1'b0, nl);
        send_frame(1'b0, 1'b0, 1'b0, 10, 1'b0, nl);
        idle(4);
        check("abort_hold_count", 64'(cap.data_count_o), 64'd40);
        check("abort_sat_count", 64'(sat.data_count_o), 64'd15);
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_leftover", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of PASS.
        @(negedge clk);
        cap.frames_i = 8'd1;
        idle(3);
        send_frame(1'b0, 1'b1, 1'b0, 0, 1'b0, nl);
        send_words(10, 1'b0, 1'b1, nl);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_reset_o", 64'(cap.cmos_reset_o), 64'd1);
        check("mid_rst_busy", 64'(cap.busy_o), 64'd0);
        check("mid_rst_en", 64'(cap.cmos_en_o), 64'd0);
        check("mid_rst_data", 64'(cap.cmos_data_o), 64'd0);
        check("mid_rst_count", 64'(cap.data_count_o), 64'd0);
        check("mid_rst_frames", 64'(cap.frame_count_o), 64'd0);
        check("mid_rst_lines", 64'(cap.lines_o), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        run_capture("after_rst", 1'b0, 1, 2, 1, 0, 5, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
